// File: rtl/vend_controller.sv
// Vending machine controller: accepts quarters/dollars up to a credit ceiling, dispenses one of two
// items with a bounded wait for the dispenser, and pays out change one coin at a time.
module vend_controller #(
    parameter int unsigned PRICE1       = 4,
    parameter int unsigned PRICE2       = 6,
    parameter int unsigned MAX_CREDIT   = 8,
    parameter int unsigned VEND_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       quarter_in_i,
    input  logic       dollar_in_i,
    input  logic [1:0] selection_i,
    input  logic       cancel_i,
    input  logic       vend_ack_i,
    input  logic       coin_ack_i,
    output logic [3:0] credit_o,
    output logic       vend_req_o,
    output logic [1:0] vend_item_o,
    output logic       coin_req_o,
    output logic       coin_type_o,
    output logic       coin_reject_o,
    output logic       busy_o
);

    localparam int unsigned TimerW = $clog2(VEND_TIMEOUT + 1);
    localparam logic [3:0] Price1 = 4'(PRICE1);
    localparam logic [3:0] Price2 = 4'(PRICE2);
    localparam logic [4:0] MaxCredit = 5'(MAX_CREDIT);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(VEND_TIMEOUT - 1);

    typedef enum logic [1:0] {StAccept, StVend, StPayout} state_e;

    state_e            state_q, state_d;
    logic [3:0]        credit_q, credit_d;
    logic [1:0]        item_q, item_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              reject_d;
    logic              vend_req_d, coin_req_d, coin_type_d, busy_d;
    logic [4:0]        credit_ext;
    logic [3:0]        item_price;
    logic              any_coin;

    assign credit_ext = {1'b0, credit_q};
    assign item_price = (item_q == 2'b10) ? Price2 : Price1;
    assign any_coin   = quarter_in_i | dollar_in_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StAccept;
            credit_q      <= '0;
            item_q        <= '0;
            timer_q       <= '0;
            vend_req_o    <= 1'b0;
            coin_req_o    <= 1'b0;
            coin_type_o   <= 1'b0;
            coin_reject_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_q        <= item_d;
            timer_q       <= timer_d;
            vend_req_o    <= vend_req_d;
            coin_req_o    <= coin_req_d;
            coin_type_o   <= coin_type_d;
            coin_reject_o <= reject_d;
            busy_o        <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        item_d   = item_q;
        timer_d  = timer_q;
        reject_d = 1'b0;
        unique case (state_q)
            StAccept: begin
                if (any_coin) begin
                    // A simultaneous dollar is always refused; only the quarter is credited.
                    if (quarter_in_i) begin
                        if (credit_ext + 5'd1 <= MaxCredit) credit_d = credit_q + 4'd1;
                        else reject_d = 1'b1;
                        if (dollar_in_i) reject_d = 1'b1;
                    end else if (credit_ext + 5'd4 <= MaxCredit) begin
                        credit_d = credit_q + 4'd4;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (selection_i == 2'b01 && credit_q >= Price1) begin
                    credit_d = credit_q - Price1;
                    item_d   = 2'b01;
                    timer_d  = '0;
                    state_d  = StVend;
                end else if (selection_i == 2'b10 && credit_q >= Price2) begin
                    credit_d = credit_q - Price2;
                    item_d   = 2'b10;
                    timer_d  = '0;
                    state_d  = StVend;
                end else if (cancel_i && credit_q != 4'd0) begin
                    state_d = StPayout;
                end
            end
            StVend: begin
                reject_d = any_coin;
                if (vend_ack_i) begin
                    state_d = (credit_q != 4'd0) ? StPayout : StAccept;
                end else if (timer_q == TimerLast) begin
                    // Dispenser never answered: refund the price and pay everything back.
                    credit_d = credit_q + item_price;
                    state_d  = StPayout;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StPayout: begin
                reject_d = any_coin;
                if (coin_ack_i) begin
                    credit_d = credit_q - (coin_type_o ? 4'd4 : 4'd1);
                    if (credit_d == 4'd0) state_d = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase
    end

    always_comb begin
        vend_req_d  = (state_d == StVend);
        coin_req_d  = (state_d == StPayout);
        coin_type_d = coin_req_d && (credit_d >= 4'd4);
        busy_d      = (state_d != StAccept);
    end

    assign credit_o    = credit_q;
    assign vend_item_o = item_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the credit/dispense rules.
module tb_vend_controller;

    localparam int P1 = 4;
    localparam int P2 = 6;
    localparam int MAXC = 8;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       qin = 1'b0, din = 1'b0, can = 1'b0, vack = 1'b0, cack = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [3:0] credit;
    logic       vend_req, coin_req, coin_type, coin_reject, busy;
    logic [1:0] vend_item;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = taking coins, 1 = waiting on dispenser, 2 = paying change.
    int m_mode = 0, m_cr = 0, m_item = 0, m_waited = 0;
    bit m_rej = 0;

    vend_controller #(
        .PRICE1(P1), .PRICE2(P2), .MAX_CREDIT(MAXC), .VEND_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .quarter_in_i(qin), .dollar_in_i(din),
        .selection_i(sel), .cancel_i(can), .vend_ack_i(vack), .coin_ack_i(cack),
        .credit_o(credit), .vend_req_o(vend_req), .vend_item_o(vend_item),
        .coin_req_o(coin_req), .coin_type_o(coin_type), .coin_reject_o(coin_reject),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic int price_of(int item);
        return (item == 2) ? P2 : P1;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_mode = 0; m_cr = 0; m_item = 0; m_waited = 0; m_rej = 0;
            return;
        end
        m_rej = (m_mode != 0) && (qin || din);
        case (m_mode)
            0: begin
                if (qin || din) begin
                    if (qin) begin
                        if (m_cr + 1 <= MAXC) m_cr = m_cr + 1;
                        else m_rej = 1;
                    end
                    if (din) begin
                        if (qin || m_cr + 4 > MAXC) m_rej = 1;
                        else m_cr = m_cr + 4;
                    end
                end else if ((sel == 2'd1 && m_cr >= P1) || (sel == 2'd2 && m_cr >= P2)) begin
                    m_item = int'(sel);
                    m_cr = m_cr - price_of(m_item);
                    m_mode = 1;
                    m_waited = 0;
                end else if (can && m_cr > 0) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (vack) begin
                    m_mode = (m_cr > 0) ? 2 : 0;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_cr = m_cr + price_of(m_item);
                        m_mode = 2;
                    end
                end
            end
            default: begin
                if (cack) begin
                    m_cr = m_cr - ((m_cr >= 4) ? 4 : 1);
                    if (m_cr == 0) m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("credit", int'(credit), m_cr);
        check("vend_req", int'(vend_req), int'(m_mode == 1));
        check("coin_req", int'(coin_req), int'(m_mode == 2));
        check("coin_type", int'(coin_type), int'(m_mode == 2 && m_cr >= 4));
        check("coin_reject", int'(coin_reject), int'(m_rej));
        check("busy", int'(busy), int'(m_mode != 0));
        if (vend_req) check("vend_item", int'(vend_item), m_item);
    endtask

    // One clock: apply inputs, let the edge happen, then advance the model and compare.
    task automatic cycle(input bit rn, input bit qq, input bit dd, input bit [1:0] ss,
                         input bit cc, input bit va, input bit ka);
        rst_n = rn; qin = qq; din = dd; sel = ss; can = cc; vack = va; cack = ka;
        @(posedge clk);
        @(negedge clk);
        model_step();
        compare_all();
    endtask

    task automatic idle();
        cycle(1, 0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0);
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
        check(name, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    int ack_pct;

    initial begin
        do_reset();
        lit("rst_credit", int'(credit), m_cr, 0);
        lit("rst_busy", int'(busy), int'(m_mode != 0), 0);

        // Four quarters then item 1, acked with no change due.
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 1, 0, 2'd0, 0, 0, 0);
            lit("q_credit", int'(credit), m_cr, i);
        end
        cycle(1, 0, 0, 2'd1, 0, 0, 0);
        lit("v1_req", int'(vend_req), int'(m_mode == 1), 1);
        lit("v1_item", int'(vend_item), m_item, 1);
        lit("v1_credit", int'(credit), m_cr, 0);
        cycle(1, 0, 0, 2'd0, 0, 1, 0);
        lit("v1_done_req", int'(vend_req), int'(m_mode == 1), 0);
        lit("v1_no_coin", int'(coin_req), int'(m_mode == 2), 0);

        // Dollar + two quarters, item 1, two quarters change.
        cycle(1, 0, 1, 2'd0, 0, 0, 0);
        idle();
        cycle(1, 1, 0, 2'd0, 0, 0, 0);
        cycle(1, 1, 0, 2'd0, 0, 0, 0);
        lit("c6", int'(credit), m_cr, 6);
        cycle(1, 0, 0, 2'd1, 0, 0, 0);
        lit("c6_after", int'(credit), m_cr, 2);
        cycle(1, 0, 0, 2'd0, 0, 1, 0);
        lit("chg_req", int'(coin_req), int'(m_mode == 2), 1);
        lit("chg_type_q", int'(coin_type), int'(m_cr >= 4), 0);
        cycle(1, 0, 0, 2'd0, 0, 0, 1);
        lit("chg_c1", int'(credit), m_cr, 1);
        cycle(1, 0, 0, 2'd0, 0, 0, 1);
        lit("chg_c0", int'(credit), m_cr, 0);
        lit("chg_idle", int'(busy), int'(m_mode != 0), 0);

        // Ceiling: credit 8 refuses a quarter.
        cycle(1, 0, 1, 2'd0, 0, 0, 0);
        cycle(1, 0, 1, 2'd0, 0, 0, 0);
        cycle(1, 1, 0, 2'd0, 0, 0, 0);
        lit("ovf_rej", int'(coin_reject), int'(m_rej), 1);
        lit("ovf_credit", int'(credit), m_cr, 8);
        // Credit 8, item 1 leaves 4; dollar change.
        cycle(1, 0, 0, 2'd1, 0, 0, 0);
        lit("c8_v", int'(credit), m_cr, 4);
        cycle(1, 0, 0, 2'd0, 0, 1, 0);
        lit("dol_type", int'(coin_type), int'(m_cr >= 4), 1);
        cycle(1, 0, 0, 2'd0, 0, 0, 1);
        lit("dol_c0", int'(credit), m_cr, 0);

        // Simultaneous quarter and dollar at credit 4.
        cycle(1, 0, 1, 2'd0, 0, 0, 0);
        cycle(1, 1, 1, 2'd0, 0, 0, 0);
        lit("qd_credit", int'(credit), m_cr, 5);
        lit("qd_rej", int'(coin_reject), int'(m_rej), 1);

        // Dispenser timeout on item 2, then refund of $1.50.
        do_reset();
        cycle(1, 0, 1, 2'd0, 0, 0, 0);
        cycle(1, 1, 0, 2'd0, 0, 0, 0);
        cycle(1, 1, 0, 2'd0, 0, 0, 0);
        cycle(1, 0, 0, 2'd2, 0, 0, 0);
        lit("to_credit0", int'(credit), m_cr, 0);
        for (int i = 0; i < TO - 1; i++) idle();
        lit("to_still", int'(vend_req), int'(m_mode == 1), 1);
        idle();
        lit("to_drop", int'(vend_req), int'(m_mode == 1), 0);
        lit("to_credit", int'(credit), m_cr, 6);
        lit("to_type", int'(coin_type), int'(m_cr >= 4), 1);
        cycle(1, 0, 0, 2'd0, 0, 0, 1);
        lit("to_c2", int'(credit), m_cr, 2);
        cycle(1, 0, 0, 2'd0, 0, 0, 1);
        cycle(1, 0, 0, 2'd0, 0, 0, 1);
        lit("to_c0", int'(credit), m_cr, 0);
        lit("to_done", int'(coin_req), int'(m_mode == 2), 0);

        // Reset in the middle of a payout.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 2'd0, 0, 0, 0);
        cycle(1, 0, 0, 2'd0, 1, 0, 0);
        lit("pay_c3", int'(credit), m_cr, 3);
        cycle(0, 0, 0, 2'd0, 0, 0, 1);
        lit("rstpay_req", int'(coin_req), int'(m_mode == 2), 0);
        lit("rstpay_credit", int'(credit), m_cr, 0);
        cycle(1, 0, 0, 2'd0, 0, 0, 1);
        lit("rstpay_ack", int'(credit), m_cr, 0);

        // Random traffic; the dispenser's responsiveness changes per block to provoke timeouts.
        for (int blk = 0; blk < 10; blk++) begin
            case (blk % 3)
                0: ack_pct = 30;
                1: ack_pct = 3;
                default: ack_pct = 0;
            endcase
            for (int c = 0; c < 400; c++) begin
                cycle($urandom_range(0, 199) != 0,
                      $urandom_range(0, 99) < 20,
                      $urandom_range(0, 99) < 10,
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 99) < 8,
                      $urandom_range(0, 99) < ack_pct,
                      $urandom_range(0, 99) < 40);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
